// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

    // Fetch sequencer states; the encoding is fixed so that traces read 0..3.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Width of the handshake statistics counter.
    localparam int STATS_W = 16;

    // Operand width: whatever is left of the ROM word after the opcode.
    function automatic int opr_width(input int data_w, input int opc_w);
        return data_w - opc_w;
    endfunction

endpackage

// File: rtl/pc_reg_p.sv
// Program counter register: a branch load wins over the increment, and the
// increment wraps modulo 2^ADDR_W.
module pc_reg_p #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    // Select the next PC: load first, then increment, otherwise hold.
    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = load_addr;
        end else if (inc) begin
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    // PC storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit_p.sv
// Instruction fetch unit: sequences requests to a 1-cycle-latency program ROM,
// captures the word into the instruction register and presents it to the
// decoder with a valid/ready handshake. Branch loads flush the held word.
// Optional build macro FETCH_STATS_EN adds a saturating handshake counter
// output fetch_count.
module fetch_unit_p
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 8,
    parameter int                OPC_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               OPR_W    = opr_width(DATA_W, OPC_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPR_W-1:0]  operand,
    output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_STATS_EN
    ,
    output logic [STATS_W-1:0] fetch_count
`endif
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [DATA_W-1:0] ir_reg;
    logic [ADDR_W-1:0] pc_out_reg;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              ir_capture;
    logic              fire;

    // A handshake completes whenever a held instruction meets a ready decoder,
    // including the cycle a branch load arrives.
    assign fire = (state_reg == HOLD) && instr_ready;

    pc_reg_p #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_addr (load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    // Next-state and capture controls; a load abandons any fetch in flight.
    always_comb begin
        state_next = state_reg;
        pc_inc     = 1'b0;
        ir_capture = 1'b0;
        if (load) begin
            state_next = enable ? REQ : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_next = REQ;
                    end
                end
                REQ: begin
                    state_next = CAP;
                end
                CAP: begin
                    state_next = HOLD;
                    pc_inc     = 1'b1;
                    ir_capture = 1'b1;
                end
                HOLD: begin
                    if (fire) begin
                        state_next = enable ? REQ : IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction register and its source address, written only on capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_reg     <= '0;
            pc_out_reg <= '0;
        end else if (ir_capture) begin
            ir_reg     <= rom_data;
            pc_out_reg <= pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [STATS_W-1:0] stats_count_reg;

    // Count completed handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats_count_reg <= '0;
        end else if (fire && (stats_count_reg != {STATS_W{1'b1}})) begin
            stats_count_reg <= stats_count_reg + STATS_W'(1);
        end
    end

    assign fetch_count = stats_count_reg;
`endif

    assign rom_addr    = pc;
    assign instr_valid = (state_reg == HOLD);
    assign opcode      = ir_reg[DATA_W-1 -: OPC_W];
    assign operand     = ir_reg[OPR_W-1:0];
    assign pc_out      = pc_out_reg;

endmodule

// File: tb/tb_fetch_unit_p.sv
// Directed testbench for fetch_unit_p with a behavioural 1-cycle ROM.
// Build with FETCH_STATS_EN defined to also exercise fetch_count.
module tb_fetch_unit_p;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;
    localparam int OPR_W  = DATA_W - OPC_W;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  opcode;
    logic [OPR_W-1:0]  operand;
    logic [ADDR_W-1:0] pc_out;
`ifdef FETCH_STATS_EN
    logic [15:0]       fetch_count;
`endif

    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

    int tests_run = 0;
    int tests_failed = 0;

    fetch_unit_p #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OPC_W    (OPC_W),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_addr   (load_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .pc_out      (pc_out)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: word appears the cycle after the address is sampled.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance at least one negedge, then wait (bounded) for a valid instruction.
    task automatic expect_instr(input string tag, input int opc, input int opr, input int pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, "_opcode"}, {28'd0, opcode}, opc);
        check_eq({tag, "_operand"}, {28'd0, operand}, opr);
        check_eq({tag, "_pc_out"}, {20'd0, pc_out}, pc);
        $display("[TB] %s: opcode=%0h operand=%0h pc_out=%03h", tag, opcode, operand, pc_out);
    endtask

    // One-cycle branch pulse applied at a negedge.
    task automatic pulse_load(input logic [ADDR_W-1:0] addr);
        load      = 1'b1;
        load_addr = addr;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
        rom[0] = 8'h1A;
        rom[1] = 8'h2B;
        rom[2] = 8'h3C;
        reset       = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        load_addr   = '0;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_rom_addr", {20'd0, rom_addr}, 32'h000);
        check_eq("rst_opcode", {28'd0, opcode}, 32'h0);
        check_eq("rst_pc_out", {20'd0, pc_out}, 32'h000);
`ifdef FETCH_STATS_EN
        check_eq("rst_count", {16'd0, fetch_count}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Sequential fetch: exact latency of 3 edges and 1 per 3 cycles
        enable      = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_lat1", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("t1_lat2", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("t1a_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t1a_op", {24'd0, opcode, operand}, 32'h1A);
        check_eq("t1a_pc", {20'd0, pc_out}, 32'h000);
        $display("[TB] t1a: opcode=%0h operand=%0h pc_out=%03h", opcode, operand, pc_out);
        repeat (3) @(negedge clk);
        check_eq("t1b_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t1b_op", {24'd0, opcode, operand}, 32'h2B);
        check_eq("t1b_pc", {20'd0, pc_out}, 32'h001);
        $display("[TB] t1b: opcode=%0h operand=%0h pc_out=%03h", opcode, operand, pc_out);
        repeat (3) @(negedge clk);
        check_eq("t1c_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t1c_op", {24'd0, opcode, operand}, 32'h3C);
        check_eq("t1c_pc", {20'd0, pc_out}, 32'h002);
        $display("[TB] t1c: opcode=%0h operand=%0h pc_out=%03h", opcode, operand, pc_out);
        enable = 1'b0;
        @(negedge clk);
        check_eq("t1_idle", {31'd0, instr_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t1_idle_stay", {31'd0, instr_valid}, 32'd0);
        check_eq("t1_idle_pc", {20'd0, rom_addr}, 32'h003);

        // Backpressure: hold the word while ready is low
        rom[0]      = 8'h5F;
        instr_ready = 1'b0;
        enable      = 1'b1;
        pulse_load(12'h000);
        expect_instr("t2", 5, 15, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("t2_hold_op", {24'd0, opcode, operand}, 32'h5F);
            check_eq("t2_hold_rom_addr", {20'd0, rom_addr}, 32'h001);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_after_fire_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t2_after_fire_state", {30'd0, dut.state_reg}, 32'd1);

        // Branch during CAP of address 4 flushes that fetch
        rom[4]      = 8'h44;
        rom[12'h800] = 8'h97;
        instr_ready = 1'b0;
        pulse_load(12'h004);
        @(negedge clk);
        check_eq("t3_in_cap", {30'd0, dut.state_reg}, 32'd2);
        check_eq("t3_cap_valid", {31'd0, instr_valid}, 32'd0);
        pulse_load(12'h800);
        check_eq("t3_flush_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t3_rom_addr", {20'd0, rom_addr}, 32'h800);
        expect_instr("t3", 9, 7, 12'h800);

        // Wrap: load in HOLD with ready high, then PC rolls over to 0
        rom[12'hFFF] = 8'hE1;
        rom[0]       = 8'h02;
        instr_ready  = 1'b1;
        pulse_load(12'hFFF);
        expect_instr("t4a", 14, 1, 12'hFFF);
        check_eq("t4a_rom_addr", {20'd0, rom_addr}, 32'h000);
        expect_instr("t4b", 0, 2, 12'h000);
        check_eq("t4b_rom_addr", {20'd0, rom_addr}, 32'h001);
        instr_ready = 1'b0;

        // Asynchronous reset during HOLD, without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check_eq("t5_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t5_rom_addr", {20'd0, rom_addr}, 32'h000);
        check_eq("t5_ir", {24'd0, opcode, operand}, 32'h00);
`ifdef FETCH_STATS_EN
        check_eq("t5_count", {16'd0, fetch_count}, 32'd0);
`endif
        @(negedge clk);
        reset       = 1'b1;
        enable      = 1'b1;
        instr_ready = 1'b1;
        expect_instr("t5a", 0, 2, 0);
        expect_instr("t5b", 2, 11, 1);
        expect_instr("t5c", 3, 12, 2);
        enable = 1'b0;
        @(negedge clk);
        check_eq("t5_idle_valid", {31'd0, instr_valid}, 32'd0);
        pulse_load(12'h123);
        check_eq("t5_load_idle", {31'd0, instr_valid}, 32'd0);
        check_eq("t5_load_addr", {20'd0, rom_addr}, 32'h123);

`ifdef FETCH_STATS_EN
        // Three handshakes plus a load, then saturation
        check_eq("stats_three", {16'd0, fetch_count}, 32'd3);
        force dut.stats_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.stats_count_reg;
        enable = 1'b1;
        expect_instr("stats_fetch", 0, 0, 12'h123);
        enable = 1'b0;
        @(negedge clk);
        check_eq("stats_saturate", {16'd0, fetch_count}, 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit_p.md
Name: fetch_unit_p

Overview:
Parametrised instruction fetch unit: program counter, synchronous-ROM request sequencing, and instruction register split into opcode/operand. Adds a valid/ready handshake toward the decoder, branch load with flush, and stall tolerance. Sits between the program ROM (external, 1-cycle read latency) and the decode/execute stage.

Parameters:
ADDR_W, 12, program counter / ROM address width
DATA_W, 8, ROM word width
OPC_W, 4, opcode width; operand width OPR_W = DATA_W - OPC_W (must be >= 1)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low
enable  input  1  allow new fetches to start
load  input  1  branch: load PC from load_addr, flush held instruction
load_addr  input  ADDR_W  branch target
rom_addr  output  ADDR_W  ROM address, always equals PC register
rom_data  input  DATA_W  ROM word; valid the cycle after rom_addr is sampled
instr_valid  output  1  opcode/operand/pc_out hold a valid instruction
instr_ready  input  1  decoder accepts instruction
opcode  output  OPC_W  IR[DATA_W-1 -: OPC_W]
operand  output  OPR_W  IR[OPR_W-1:0]
pc_out  output  ADDR_W  address the held instruction came from

Behaviour:
- Reset (reset=0, async): state=IDLE, PC=RESET_PC, IR=0, pc_out=0, instr_valid=0. Outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, REQ, CAP, HOLD. instr_valid=1 only in HOLD.
- IDLE: enable=1 -> REQ; else stay.
- REQ: ROM samples rom_addr=PC at this edge -> CAP (unconditional).
- CAP: IR<=rom_data, pc_out<=PC, PC<=PC+1 -> HOLD.
- HOLD: handshake fires when instr_valid & instr_ready. On fire: enable=1 -> REQ, else -> IDLE. No fire: stay, IR/pc_out stable.
- Latency: enable asserted in IDLE -> instr_valid high 3 edges later; steady-state throughput 1 instruction per 3 cycles with ready held high.
- PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 increments to 0, no flag.
- load (priority over all but reset), any state: PC<=load_addr, IR unchanged but instr_valid=0 next cycle; next state REQ if enable else IDLE. An in-flight REQ/CAP is abandoned (CAP does not write IR or increment PC).
- load in HOLD with instr_ready=1 same cycle: the handshake counts as completed (decoder consumed it), then load applies.
- enable dropped during REQ/CAP: current fetch completes to HOLD; transition to IDLE after that handshake.
- instr_ready ignored outside HOLD.

Optional Feature:
FETCH_STATS_EN defined: extra output fetch_count [15:0], increments on every handshake fire, saturates at 16'hFFFF, reset to 0, unaffected by load. Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg: state typedef enum {IDLE, REQ, CAP, HOLD} (2-bit encoding 0..3), localparam helper for OPR_W.
- Sub-module pc_reg_p (ADDR_W, RESET_PC): async active-low reset, load/increment register with load priority; FSM and IR live in the top module.

Test Plan:
- Reset/sequential fetch: ROM[0..2]=8'h1A,8'h2B,8'h3C, enable=1, ready=1 -> handshakes deliver (opcode,operand,pc_out)=(1,A,0),(2,B,1),(3,C,2), one every 3 cycles.
- Backpressure: ready=0 for 5 cycles in HOLD with ROM[0]=8'h5F -> instr_valid stays 1, opcode=5, operand=F, rom_addr=1 stable; ready=1 -> one handshake, then REQ.
- Branch/flush: during CAP of addr 4, load=1, load_addr=12'h800, ROM[800]=8'h97 -> addr 4 word never presented; next valid instruction opcode=9, operand=7, pc_out=800.
- Wrap: load_addr=12'hFFF, ROM[FFF]=8'hE1, ROM[0]=8'h02 -> pc_out FFF then 000; rom_addr wraps to 0.
- Reset mid-operation: assert reset asynchronously during HOLD -> instr_valid=0, rom_addr=RESET_PC immediately without a clock edge; after release, fetch restarts from RESET_PC.
- FETCH_STATS_EN build: 3 handshakes plus one load -> fetch_count=3; force 16'hFFFF then another handshake -> remains FFFF.
